// File: rtl/rv32i_hazard_unit.sv
// rv32i_hazard_unit: data-hazard and operand-forwarding controller for the RV32I in-order pipeline.
//
// The unit keeps a shadow scoreboard of the instructions in flight after decode. Entry index 0
// holds EXE (stage 1), index 1 holds MEM (stage 2), and so on. Each entry records
// {valid, rd, we, load}. From this scoreboard the unit drives a decode stall and a
// per-operand forwarding select, and it squashes the decode slot on control redirects.
//
// Build option:
//   RV32I_HAZARD_FWD_EN  defined   -> forwarding; only a load hit younger than LOAD_READY stalls.
//                        undefined -> full interlock; every hit stalls and the selects are 0.
//
// Ports:
//   clk_i, resetn_i          clock and asynchronous active-low reset
//   advance_i                pipeline advances this cycle; the scoreboard shifts
//   dec_*_i                  decode-slot instruction: sources, destination, load flag
//   redirect_i               taken branch or jump; kills the decode instruction
//   stall_o, squash_o        hold decode and inject a bubble / decode slot becomes a bubble
//   fwd_rs1_sel_o, fwd_rs2_sel_o  0 = register file, k = forward from stage k
//   inflight_o               count of valid writing entries
//   stall_cnt_o              saturating count of stalled advancing cycles
module rv32i_hazard_unit #(
  parameter int unsigned NB_STAGES  = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              advance_i,
  input  logic              dec_valid_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic              dec_rs1_used_i,
  input  logic              dec_rs2_used_i,
  input  logic [REG_AW-1:0] dec_rd_i,
  input  logic              dec_rd_we_i,
  input  logic              dec_is_load_i,
  input  logic              redirect_i,
  output logic              stall_o,
  output logic              squash_o,
  output logic [2:0]        fwd_rs1_sel_o,
  output logic [2:0]        fwd_rs2_sel_o,
  output logic [2:0]        inflight_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [NB_STAGES-1:0]             r_valid;
  logic [NB_STAGES-1:0]             r_we;
  logic [NB_STAGES-1:0]             r_load;
  logic [NB_STAGES-1:0][REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]                 r_stall_cnt;

  logic       w_hit1, w_hit2;
  logic       w_haz1, w_haz2;
  logic [2:0] w_sel1, w_sel2;
  logic       w_issue;
  logic       w_dec_we;
  logic [2:0] w_inflight;

`ifdef RV32I_HAZARD_FWD_EN
  logic [2:0] w_k1, w_k2;
  logic       w_ld1, w_ld2;

  // Walk from the oldest stage to the youngest so the youngest match is the one that sticks.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_k1   = '0;
    w_k2   = '0;
    w_ld1  = 1'b0;
    w_ld2  = 1'b0;
    for (int k = NB_STAGES; k >= 1; k--) begin
      if (r_valid[k-1] && r_we[k-1] && (r_rd[k-1] == dec_rs1_i)) begin
        w_hit1 = 1'b1;
        w_k1   = 3'(k);
        w_ld1  = r_load[k-1];
      end
      if (r_valid[k-1] && r_we[k-1] && (r_rd[k-1] == dec_rs2_i)) begin
        w_hit2 = 1'b1;
        w_k2   = 3'(k);
        w_ld2  = r_load[k-1];
      end
    end
    w_hit1 = w_hit1 & dec_rs1_used_i & (dec_rs1_i != '0);
    w_hit2 = w_hit2 & dec_rs2_used_i & (dec_rs2_i != '0);
    // Load data not yet available at the hit stage: cannot forward.
    w_haz1 = w_hit1 & w_ld1 & (w_k1 < 3'(LOAD_READY));
    w_haz2 = w_hit2 & w_ld2 & (w_k2 < 3'(LOAD_READY));
    w_sel1 = (w_hit1 && !w_haz1) ? w_k1 : 3'd0;
    w_sel2 = (w_hit2 && !w_haz2) ? w_k2 : 3'd0;
  end
`else
  logic w_unused_load;
  assign w_unused_load = dec_is_load_i ^ (^r_load) ^ (LOAD_READY == 0);

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 0; k < NB_STAGES; k++) begin
      if (r_valid[k] && r_we[k] && (r_rd[k] == dec_rs1_i)) w_hit1 = 1'b1;
      if (r_valid[k] && r_we[k] && (r_rd[k] == dec_rs2_i)) w_hit2 = 1'b1;
    end
    w_hit1 = w_hit1 & dec_rs1_used_i & (dec_rs1_i != '0);
    w_hit2 = w_hit2 & dec_rs2_used_i & (dec_rs2_i != '0);
    w_haz1 = w_hit1;
    w_haz2 = w_hit2;
    w_sel1 = 3'd0;
    w_sel2 = 3'd0;
  end
`endif

  always_comb begin
    stall_o       = dec_valid_i & (w_haz1 | w_haz2);
    squash_o      = stall_o | redirect_i;
    fwd_rs1_sel_o = stall_o ? 3'd0 : w_sel1;
    fwd_rs2_sel_o = stall_o ? 3'd0 : w_sel2;
  end

  assign w_issue  = dec_valid_i & ~stall_o & ~redirect_i;
  // Writes to x0 never produce a result anyone can depend on.
  assign w_dec_we = dec_rd_we_i & (dec_rd_i != '0);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_valid <= '0;
      r_we    <= '0;
      r_load  <= '0;
      r_rd    <= '0;
    end else if (advance_i) begin
      if (NB_STAGES > 1) begin
        r_valid <= {r_valid[NB_STAGES-2:0], w_issue};
        r_we    <= {r_we[NB_STAGES-2:0], w_issue & w_dec_we};
        r_load  <= {r_load[NB_STAGES-2:0], w_issue & dec_is_load_i};
        r_rd    <= {r_rd[NB_STAGES-2:0], dec_rd_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_stall_cnt <= '0;
    end else if (advance_i && stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < NB_STAGES; k++) begin
      w_inflight = w_inflight + {2'b00, r_valid[k] & r_we[k]};
    end
  end

  assign inflight_o  = w_inflight;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Self-checking bench for rv32i_hazard_unit (default parameters). Expected values follow the
// build mode selected by RV32I_HAZARD_FWD_EN.
module tb_rv32i_hazard_unit;

  logic        clk;
  logic        resetn;
  logic        advance;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used;
  logic        dec_rd_we, dec_is_load;
  logic        redirect;
  logic        stall, squash;
  logic [2:0]  sel1, sel2, inflight;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        adv, dv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        we, ld, re;
    logic        e_st, e_sq;
    logic [2:0]  e_s1, e_s2, e_inf;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  rv32i_hazard_unit dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .advance_i      (advance),
    .dec_valid_i    (dec_valid),
    .dec_rs1_i      (dec_rs1),
    .dec_rs2_i      (dec_rs2),
    .dec_rs1_used_i (dec_rs1_used),
    .dec_rs2_used_i (dec_rs2_used),
    .dec_rd_i       (dec_rd),
    .dec_rd_we_i    (dec_rd_we),
    .dec_is_load_i  (dec_is_load),
    .redirect_i     (redirect),
    .stall_o        (stall),
    .squash_o       (squash),
    .fwd_rs1_sel_o  (sel1),
    .fwd_rs2_sel_o  (sel2),
    .inflight_o     (inflight),
    .stall_cnt_o    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int adv, dv, rs1, u1, rs2, u2, rd, we, ld, re,
                              input int st, sq, s1, s2, inf, cnt);
    vec_t v;
    v.adv = 1'(adv); v.dv = 1'(dv); v.rs1 = 5'(rs1); v.u1 = 1'(u1);
    v.rs2 = 5'(rs2); v.u2 = 1'(u2); v.rd = 5'(rd); v.we = 1'(we);
    v.ld = 1'(ld); v.re = 1'(re);
    v.e_st = 1'(st); v.e_sq = 1'(sq); v.e_s1 = 3'(s1); v.e_s2 = 3'(s2);
    v.e_inf = 3'(inf); v.e_cnt = 16'(cnt);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    advance = v.adv; dec_valid = v.dv; dec_rs1 = v.rs1; dec_rs1_used = v.u1;
    dec_rs2 = v.rs2; dec_rs2_used = v.u2; dec_rd = v.rd; dec_rd_we = v.we;
    dec_is_load = v.ld; redirect = v.re;
  endtask

  task automatic check(input string nm, input vec_t v);
    n_vec++;
    if (stall !== v.e_st || squash !== v.e_sq || sel1 !== v.e_s1 || sel2 !== v.e_s2 ||
        inflight !== v.e_inf || stall_cnt !== v.e_cnt) begin
      n_bad++;
      $display("FAIL %s: got st=%0b sq=%0b s1=%0d s2=%0d inf=%0d cnt=%0d, want st=%0b sq=%0b s1=%0d s2=%0d inf=%0d cnt=%0d",
               nm, stall, squash, sel1, sel2, inflight, stall_cnt,
               v.e_st, v.e_sq, v.e_s1, v.e_s2, v.e_inf, v.e_cnt);
    end
  endtask

  initial begin
    vec_t v;
    //               adv dv rs1 u1 rs2 u2 rd we ld re | st sq s1 s2 inf cnt
`ifdef RV32I_HAZARD_FWD_EN
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0));  // addi x5
    vecs.push_back(mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0,  0, 0, 1, 1, 1, 0));  // add x6,x5,x5
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 2, 0));  // lw x7
    vecs.push_back(mk(1, 1, 7, 1, 0, 1, 8, 1, 0, 0,  1, 1, 0, 0, 3, 0));  // load-use stall
    vecs.push_back(mk(1, 1, 7, 1, 0, 1, 8, 1, 0, 0,  0, 0, 2, 0, 2, 1));  // forward from MEM
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 8, 1, 0, 0, 5, 1, 0, 0,  0, 0, 3, 0, 3, 1));  // forward from WB
    vecs.push_back(mk(1, 1, 5, 1, 9, 1, 6, 1, 0, 0,  0, 0, 1, 2, 3, 1));  // x5 in EXE and WB
    vecs.push_back(mk(1, 1, 5, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 3, 1));  // rs1 unused, wr x0
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 9, 1, 0, 1,  0, 1, 0, 0, 2, 1));  // redirect kills x9
    vecs.push_back(mk(1, 1, 9, 1, 6, 1, 0, 0, 0, 0,  0, 0, 0, 3, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0, 1));  // lw x7
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 7, 1, 0, 0, 8, 1, 0, 0,  1, 1, 0, 0, 1, 1)); // held stall
    vecs.push_back(mk(1, 1, 7, 1, 0, 0, 8, 1, 0, 0,  1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 7, 1, 0, 0, 8, 1, 0, 0,  0, 0, 2, 0, 1, 2));
    vecs.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 2));
`else
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0));  // addi x5
    vecs.push_back(mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0,  1, 1, 0, 0, 1, 0));  // stall at EXE
    vecs.push_back(mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0,  1, 1, 0, 0, 1, 1));  // stall at MEM
    vecs.push_back(mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0,  1, 1, 0, 0, 1, 2));  // stall at WB
    vecs.push_back(mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0, 3));  // issues
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 6, 1, 0, 0, 7, 1, 0, 0,  1, 1, 0, 0, 1, 3)); // held stall
    vecs.push_back(mk(1, 0, 6, 1, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 1, 3));  // invalid slot
    vecs.push_back(mk(1, 1, 0, 1, 6, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 3));  // wr x0, rs2 unused
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 9, 1, 0, 1,  0, 1, 0, 0, 1, 3));  // redirect kills x9
    vecs.push_back(mk(1, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 3));  // redirect + hazard
    vecs.push_back(mk(1, 1, 0, 0, 10, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4));
    vecs.push_back(mk(1, 1, 10, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5));  // rs1 unused
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 5));
`endif

    // Reset state, with and without redirect.
    resetn = 1'b0;
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    #1 check("reset_redirect", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    redirect = 1'b0;
    #1 check("reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted in the middle of a load-use sequence.
    @(negedge clk);
    resetn = 1'b0;
    #1 resetn = 1'b1;
    v = mk(1, 1, 0, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    drive(v);
    #1 check("seq_lw", v);
    @(negedge clk);
    v = mk(1, 1, 7, 1, 0, 0, 8, 1, 0, 0,  1, 1, 0, 0, 1, 0);
    drive(v);
    #1 check("seq_use", v);
    @(negedge clk);
`ifdef RV32I_HAZARD_FWD_EN
    #1 check("seq_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1, 1));
`else
    #1 check("seq_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1));
`endif
    #1 resetn = 1'b0;
    #1 check("seq_async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetn = 1'b1;
    #1 check("seq_post_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
